// File: rtl/fifo_1_2.sv
// Single-clock FIFO of depth 1 or 2 with registered head data and registered FULL_N/EMPTY_N.
// Outputs come straight from flops, so there is no combinational path from any input.
module fifo_1_2 #(
    parameter int width = 8,
    parameter int depth = 2
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [width-1:0] D_IN,
    input  logic             ENQ,
    input  logic             DEQ,
    input  logic             CLR,
    output logic [width-1:0] D_OUT,
    output logic             FULL_N,
    output logic             EMPTY_N
);

    if (depth != 1 && depth != 2) begin : g_bad_depth
        $error("fifo_1_2: depth must be 1 or 2");
    end

    localparam logic [1:0] DEPTH_C = 2'(depth);

    logic [1:0]       count_p0, count_nxt;
    logic [width-1:0] data0_p0, data0_nxt;
    logic [width-1:0] data1_p0, data1_nxt;
    logic             full_n_p0, empty_n_p0;
    logic             enq_ok, deq_ok;

    // Requests only take effect against the registered flags, so ignored ones leave state alone.
    assign enq_ok = ENQ && full_n_p0;
    assign deq_ok = DEQ && empty_n_p0;

    always_comb begin
        count_nxt = count_p0;
        data0_nxt = data0_p0;
        data1_nxt = data1_p0;
        if (CLR) begin
            count_nxt = 2'd0;
        end else begin
            unique case (count_p0)
                2'd0: begin
                    if (enq_ok) begin
                        data0_nxt = D_IN;
                        count_nxt = 2'd1;
                    end
                end
                2'd1: begin
                    // Depth 1 never sees enq_ok here since FULL_N is low.
                    if (enq_ok && deq_ok) begin
                        data0_nxt = D_IN;
                    end else if (enq_ok) begin
                        data1_nxt = D_IN;
                        count_nxt = 2'd2;
                    end else if (deq_ok) begin
                        count_nxt = 2'd0;
                    end
                end
                2'd2: begin
                    if (deq_ok) begin
                        data0_nxt = data1_p0;
                        count_nxt = 2'd1;
                    end
                end
                default: count_nxt = 2'd0;
            endcase
        end
    end

    // ---- state / output register stage ----
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            count_p0   <= 2'd0;
            data0_p0   <= '0;
            data1_p0   <= '0;
            full_n_p0  <= 1'b1;
            empty_n_p0 <= 1'b0;
        end else begin
            count_p0   <= count_nxt;
            data0_p0   <= data0_nxt;
            data1_p0   <= data1_nxt;
            full_n_p0  <= (count_nxt < DEPTH_C);
            empty_n_p0 <= (count_nxt != 2'd0);
        end
    end

    assign D_OUT   = data0_p0;
    assign FULL_N  = full_n_p0;
    assign EMPTY_N = empty_n_p0;

endmodule

// File: tb/tb_fifo_1_2.sv
// Drives depth-1 and depth-2 instances with shared stimulus and compares both against queue models.
module tb_fifo_1_2;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic [7:0] D_IN = 8'h00;
    logic       ENQ = 1'b0;
    logic       DEQ = 1'b0;
    logic       CLR = 1'b0;
    logic [7:0] D_OUT1, D_OUT2;
    logic       FULL_N1, FULL_N2, EMPTY_N1, EMPTY_N2;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] q1[$];
    logic [7:0] q2[$];

    always #5 CLK = ~CLK;

    fifo_1_2 #(.width(8), .depth(1)) u_d1 (
        .CLK(CLK), .RST_N(RST_N), .D_IN(D_IN), .ENQ(ENQ), .DEQ(DEQ), .CLR(CLR),
        .D_OUT(D_OUT1), .FULL_N(FULL_N1), .EMPTY_N(EMPTY_N1)
    );

    fifo_1_2 #(.width(8), .depth(2)) u_d2 (
        .CLK(CLK), .RST_N(RST_N), .D_IN(D_IN), .ENQ(ENQ), .DEQ(DEQ), .CLR(CLR),
        .D_OUT(D_OUT2), .FULL_N(FULL_N2), .EMPTY_N(EMPTY_N2)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check_val({tag, ".d1.empty_n"}, 32'(EMPTY_N1), 32'(q1.size() > 0));
        check_val({tag, ".d1.full_n"},  32'(FULL_N1),  32'(q1.size() < 1));
        if (q1.size() > 0) check_val({tag, ".d1.d_out"}, 32'(D_OUT1), 32'(q1[0]));
        check_val({tag, ".d2.empty_n"}, 32'(EMPTY_N2), 32'(q2.size() > 0));
        check_val({tag, ".d2.full_n"},  32'(FULL_N2),  32'(q2.size() < 2));
        if (q2.size() > 0) check_val({tag, ".d2.d_out"}, 32'(D_OUT2), 32'(q2[0]));
    endtask

    // Queue semantics: acceptance decided on occupancy before the edge, dequeue before enqueue.
    task automatic model_edge(input logic e, input logic d, input logic c, input logic [7:0] din);
        bit e1, d1, e2, d2;
        e1 = e && (q1.size() < 1);
        d1 = d && (q1.size() > 0);
        e2 = e && (q2.size() < 2);
        d2 = d && (q2.size() > 0);
        if (c) begin
            q1.delete();
            q2.delete();
        end else begin
            if (d1) void'(q1.pop_front());
            if (e1) q1.push_back(din);
            if (d2) void'(q2.pop_front());
            if (e2) q2.push_back(din);
        end
    endtask

    task automatic step(input string tag, input logic e, input logic d, input logic c, input logic [7:0] din);
        ENQ = e; DEQ = d; CLR = c; D_IN = din;
        @(posedge CLK);
        #1;
        model_edge(e, d, c, din);
        check_all(tag);
    endtask

    task automatic idle();
        ENQ = 1'b0; DEQ = 1'b0; CLR = 1'b0;
    endtask

    initial begin
        idle();
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1'b1;
        check_all("por");

        // Reset mid-cycle with depth-2 holding two entries
        step("pre_rst0", 1, 0, 0, 8'hAA);
        step("pre_rst1", 1, 0, 0, 8'hBB);
        check_val("pre_rst.d2.full_n", 32'(FULL_N2), 32'd0);
        idle();
        #3;
        RST_N = 1'b0;
        #1;
        q1.delete();
        q2.delete();
        check_all("async_rst");
        check_val("async_rst.d2.d_out", 32'(D_OUT2), 32'h0);
        check_val("async_rst.d1.d_out", 32'(D_OUT1), 32'h0);
        @(posedge CLK);
        #1;
        check_all("rst_held");
        check_val("rst_held.d2.d_out", 32'(D_OUT2), 32'h0);
        @(negedge CLK);
        RST_N = 1'b1;
        step("post_rst_enq", 1, 0, 0, 8'h3C);
        check_val("post_rst.d2.d_out", 32'(D_OUT2), 32'h3C);
        step("post_rst_deq", 0, 1, 0, 8'h00);

        // Depth-2 fill and drain, with a drop while full
        step("fill0", 1, 0, 0, 8'h11);
        step("fill1", 1, 0, 0, 8'h22);
        step("fill_drop", 1, 0, 0, 8'h33);
        check_val("fill.d2.head", 32'(D_OUT2), 32'h11);
        step("drain0", 0, 1, 0, 8'h00);
        check_val("drain0.d2.head", 32'(D_OUT2), 32'h22);
        step("drain1", 0, 1, 0, 8'h00);
        step("drain2", 0, 1, 0, 8'h00);
        step("drain_extra", 0, 1, 0, 8'h00);

        // Simultaneous ENQ/DEQ at count 1
        step("sim1_load", 1, 0, 0, 8'hA5);
        step("sim1", 1, 1, 0, 8'h5A);
        check_val("sim1.d2.d_out", 32'(D_OUT2), 32'h5A);
        step("sim1_clean0", 0, 1, 0, 8'h00);
        step("sim1_clean1", 0, 1, 0, 8'h00);

        // Simultaneous ENQ/DEQ at count 2: the enqueue is dropped
        step("sim2_l0", 1, 0, 0, 8'h01);
        step("sim2_l1", 1, 0, 0, 8'h02);
        step("sim2", 1, 1, 0, 8'h03);
        check_val("sim2.d2.d_out", 32'(D_OUT2), 32'h02);
        step("sim2_deq", 0, 1, 0, 8'h00);
        check_val("sim2_deq.d2.empty_n", 32'(EMPTY_N2), 32'd0);

        // Depth-1 behaviour, back-to-back enqueue
        step("d1_enq", 1, 0, 0, 8'h7E);
        check_val("d1_enq.full_n", 32'(FULL_N1), 32'd0);
        step("d1_enqdeq", 1, 1, 0, 8'h7F);
        check_val("d1_enqdeq.empty_n", 32'(EMPTY_N1), 32'd0);
        step("d2_flush", 0, 1, 0, 8'h00);
        for (int i = 0; i < 6; i++) step("b2b", 1, 1, 0, 8'h80 + 8'(i));
        step("b2b_end0", 0, 1, 0, 8'h00);
        step("b2b_end1", 0, 1, 0, 8'h00);

        // CLR overrides ENQ and DEQ
        step("clr_l0", 1, 0, 0, 8'h10);
        step("clr_l1", 1, 0, 0, 8'h20);
        step("clr", 1, 1, 1, 8'h44);
        check_val("clr.d2.empty_n", 32'(EMPTY_N2), 32'd0);
        check_val("clr.d2.full_n", 32'(FULL_N2), 32'd1);

        // Random traffic
        for (int n = 0; n < 500; n++) begin
            step("rnd", 1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 9) < 5),
                 1'($urandom_range(0, 39) == 0), 8'($urandom));
        end

        idle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
